// File: rtl/li_pkg.sv
// Shared constants, FSM state type and RV32I encoders for the li pseudo-instruction expander.
package li_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  localparam logic [6:0]      OPC_OPIMM = 7'b0010011;
  localparam logic [6:0]      OPC_LUI   = 7'b0110111;
  localparam logic [2:0]      F3_ADDI   = 3'b000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT1 = 2'd1,
    EMIT2 = 2'd2
  } state_e;

  function automatic logic [XLEN-1:0] enc_addi(input logic [REG_W-1:0] rd,
                                               input logic [REG_W-1:0] rs1,
                                               input logic [11:0]      imm12);
    return {imm12, rs1, F3_ADDI, rd, OPC_OPIMM};
  endfunction

  function automatic logic [XLEN-1:0] enc_lui(input logic [REG_W-1:0] rd,
                                              input logic [19:0]      imm20);
    return {imm20, rd, OPC_LUI};
  endfunction

endpackage

// File: rtl/li_split.sv
// Splits a 32-bit constant into the LUI upper part and the sign-extended ADDI lower part.
module li_split #(
  parameter int unsigned IMM_W = 12
) (
  input  logic [31:0]       imm,
  output logic              fits,
  output logic              two_beats,
  output logic [31-IMM_W:0] hi,
  output logic [IMM_W-1:0]  lo
);

  localparam int unsigned HI_W = 32 - IMM_W;

  always_comb begin
    fits      = (&imm[31:IMM_W-1]) || !(|imm[31:IMM_W-1]);
    lo        = imm[IMM_W-1:0];
    // Adding 2^(IMM_W-1) only carries into the upper part when the lo sign bit is set.
    hi        = imm[31:IMM_W] + HI_W'(imm[IMM_W-1]);
    two_beats = !fits && (lo != '0);
  end

endmodule

// File: rtl/li_expander.sv
// Streaming expander for `li rd, imm32` into ADDI / LUI / LUI+ADDI beats.
// Optional round-trip self check enabled by defining LI_ROUNDTRIP_CHECK_EN.
module li_expander
  import li_pkg::*;
#(
  parameter int unsigned IMM_W     = 12,
  parameter bit          NOP_ON_X0 = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last,
  output logic        chk_err
);

  localparam int unsigned HI_W = 32 - IMM_W;

  state_e             state_q, state_d;
  logic [REG_W-1:0]   rd_q, rd_d;
  logic [IMM_W-1:0]   lo_q, lo_d;
  logic               out_valid_q, out_valid_d;
  logic [XLEN-1:0]    out_instr_q, out_instr_d;
  logic               out_last_q, out_last_d;

  logic               sp_fits, sp_two;
  logic [HI_W-1:0]    sp_hi;
  logic [IMM_W-1:0]   sp_lo;
  logic               hs, last_hs, accept, is_nop;

  li_split #(.IMM_W(IMM_W)) u_split (
    .imm       (in_imm),
    .fits      (sp_fits),
    .two_beats (sp_two),
    .hi        (sp_hi),
    .lo        (sp_lo)
  );

  // Next-state and first/second beat selection.
  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    lo_d        = lo_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_last_d  = out_last_q;

    hs       = out_valid_q && out_ready;
    last_hs  = hs && out_last_q;
    in_ready = (state_q == IDLE) || last_hs;
    accept   = in_valid && in_ready;
    is_nop   = NOP_ON_X0 && (in_rd == '0);

    case (state_q)
      EMIT1: begin
        if (hs && !out_last_q) begin
          state_d     = EMIT2;
          out_instr_d = enc_addi(rd_q, rd_q, lo_q);
          out_last_d  = 1'b1;
        end else if (last_hs) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      EMIT2: begin
        if (last_hs) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: ;
    endcase

    // A new accept on the last handshake overrides the return to IDLE.
    if (accept) begin
      state_d     = EMIT1;
      out_valid_d = 1'b1;
      rd_d        = in_rd;
      lo_d        = sp_lo;
      if (is_nop) begin
        out_instr_d = NOP_INSTR;
        out_last_d  = 1'b1;
      end else if (sp_fits) begin
        out_instr_d = enc_addi(in_rd, '0, sp_lo);
        out_last_d  = 1'b1;
      end else begin
        out_instr_d = enc_lui(in_rd, sp_hi);
        out_last_d  = !sp_two;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_q        <= '0;
      lo_q        <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      lo_q        <= lo_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_last  = out_last_q;

`ifdef LI_ROUNDTRIP_CHECK_EN
  logic [XLEN-1:0] imm_q, imm_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic            nop_q, nop_d;
  logic            chk_err_q, chk_err_d;

  // Replays emitted beats into a shadow register and compares on the last beat.
  always_comb begin
    imm_d     = imm_q;
    acc_d     = acc_q;
    nop_d     = nop_q;
    chk_err_d = chk_err_q;
    if (hs && !nop_q) begin
      if (out_instr_q[6:0] == OPC_LUI) begin
        acc_d = {out_instr_q[31:12], 12'b0};
      end else begin
        acc_d = ((out_instr_q[19:15] == '0) ? '0 : acc_q)
              + {{20{out_instr_q[31]}}, out_instr_q[31:20]};
      end
      if (out_last_q && (acc_d != imm_q)) begin
        chk_err_d = 1'b1;
      end
    end
    if (accept) begin
      imm_d = in_imm;
      nop_d = is_nop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_q     <= '0;
      acc_q     <= '0;
      nop_q     <= 1'b0;
      chk_err_q <= 1'b0;
    end else begin
      imm_q     <= imm_d;
      acc_q     <= acc_d;
      nop_q     <= nop_d;
      chk_err_q <= chk_err_d;
    end
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_li_expander.sv
// Self-checking bench for li_expander: queue-based reference of expected beats plus directed pins.
module tb_li_expander;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic        out_last;
  logic        chk_err;

  int checks = 0;
  int errors = 0;
  int or_mode = 0;          // 0: always ready, 1: never ready, 2: random
  logic [31:0] exp_q[$];    // expected beats still to be emitted

  li_expander dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rd     (in_rd),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_last  (out_last),
    .chk_err   (chk_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: shortest sequence derived from the constant's numeric value.
  function automatic void model(input logic [4:0] rd, input logic [31:0] imm,
                                output int n, output logic [31:0] b0, output logic [31:0] b1);
    int          s;
    logic [31:0] lo, hi, rdw;
    s   = int'(imm);
    lo  = imm & 32'h0000_0FFF;
    hi  = (imm + 32'h0000_0800) >> 12;
    rdw = {27'd0, rd};
    b1  = 32'd0;
    if (rd == 5'd0) begin
      n  = 1;
      b0 = 32'h0000_0013;
    end else if (s >= -2048 && s <= 2047) begin
      n  = 1;
      b0 = (lo << 20) | (rdw << 7) | 32'h13;
    end else begin
      b0 = (hi << 12) | (rdw << 7) | 32'h37;
      if (lo == 32'd0) n = 1;
      else begin
        n  = 2;
        b1 = (lo << 20) | (rdw << 15) | (rdw << 7) | 32'h13;
      end
    end
  endfunction

  always @(posedge clk) begin
    #2;
    case (or_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Compare process: every cycle check handshake signals and the head beat.
  always @(negedge clk) begin
    int n;
    logic [31:0] b0, b1;
    if (!rst_n) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
    end else begin
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("in_ready", 32'(in_ready),
          32'((exp_q.size() == 0) || (out_ready && exp_q.size() == 1)));
      chk("chk_err", 32'(chk_err), 32'd0);
      if (out_valid && exp_q.size() != 0) begin
        chk("out_instr", out_instr, exp_q[0]);
        chk("out_last", 32'(out_last), 32'(exp_q.size() == 1));
      end
      if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (in_valid && in_ready) begin
        model(in_rd, in_imm, n, b0, b1);
        exp_q.push_back(b0);
        if (n == 2) exp_q.push_back(b1);
      end
    end
  end

  // Leaves in_valid high after acceptance so callers can chain requests.
  task automatic send(input logic [4:0] rd, input logic [31:0] imm);
    int cyc = 0;
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_rd    = rd;
    in_imm   = imm;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end while (!acc && cyc < 1000);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: request rd=%0d imm=%08h never accepted", rd, imm);
    end
  endtask

  task automatic drain();
    int c = 0;
    in_valid = 1'b0;
    while ((exp_q.size() != 0 || out_valid) && c < 500) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (c >= 500) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d beats still pending", exp_q.size());
    end
  endtask

  task automatic pin(input string name, input logic [4:0] rd, input logic [31:0] imm,
                     input int en, input logic [31:0] e0, input logic [31:0] e1);
    int n;
    logic [31:0] b0, b1;
    model(rd, imm, n, b0, b1);
    chk({name, "_n"}, 32'(n), 32'(en));
    chk({name, "_b0"}, b0, e0);
    if (en == 2) chk({name, "_b1"}, b1, e1);
  endtask

  function automatic logic [31:0] rand_imm();
    logic [31:0] edges[8];
    edges = '{32'h7FFF_F800, 32'hFFFF_F800, 32'h0000_07FF, 32'h0000_0800,
              32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_F7FF, 32'h0000_0000};
    case ($urandom_range(0, 4))
      0: return edges[$urandom_range(0, 7)];
      1: return 32'($urandom_range(0, 4095)) - 32'd2048;
      2: return $urandom() & 32'hFFFF_F000;
      3: return $urandom() | 32'h0000_0800;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic [31:0] held;
    in_valid = 1'b0;
    in_rd    = 5'd0;
    in_imm   = 32'd0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_instr", out_instr, 32'd0);
    chk("reset_out_last", 32'(out_last), 32'd0);
    chk("reset_chk_err", 32'(chk_err), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    pin("pin_7f",      5'd5,  32'h0000_007F, 1, 32'h07F0_0293, 32'h0);
    pin("pin_m2048",   5'd5,  32'hFFFF_F800, 1, 32'h8000_0293, 32'h0);
    pin("pin_1234",    5'd10, 32'h1234_5678, 2, 32'h1234_5537, 32'h6785_0513);
    pin("pin_1000",    5'd1,  32'h0000_1000, 1, 32'h0000_10B7, 32'h0);
    pin("pin_7ffff800",5'd2,  32'h7FFF_F800, 2, 32'h8000_0137, 32'h8001_0113);
    pin("pin_nop",     5'd0,  32'h1234_5678, 1, 32'h0000_0013, 32'h0);

    // Directed, one at a time.
    send(5'd5, 32'h0000_007F);  drain();
    send(5'd5, 32'hFFFF_F800);  drain();
    send(5'd10, 32'h1234_5678); drain();
    send(5'd1, 32'h0000_1000);  drain();
    send(5'd2, 32'h7FFF_F800);  drain();
    send(5'd0, 32'h1234_5678);  drain();
    send(5'd3, 32'h0000_07FF);  drain();
    send(5'd4, 32'h0000_0800);  drain();

    // Back-to-back with no idle gap.
    send(5'd10, 32'h1234_5678);
    send(5'd5, 32'h0000_007F);
    send(5'd2, 32'h7FFF_F800);
    send(5'd1, 32'h0000_1000);
    send(5'd4, 32'h0000_0800);
    drain();

    // Backpressure on the first beat.
    or_mode = 1;
    send(5'd10, 32'h1234_5678);
    in_valid = 1'b0;
    held = out_instr;
    chk("bp_first_beat", held, 32'h1234_5537);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("bp_stable", out_instr, held);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    or_mode = 0;
    drain();

    // Reset while the second beat is pending.
    send(5'd10, 32'h1234_5678);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("emit2_instr", out_instr, 32'h6785_0513);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_valid", 32'(out_valid), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Randomized traffic with random backpressure and gaps.
    or_mode = 2;
    for (int i = 0; i < 300; i++) begin
      send(5'($urandom_range(0, 31)), rand_imm());
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    or_mode = 0;
    drain();
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
